// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// port identifiers and the default block/address widths.
package mem_arb_pkg;

   localparam int DEFAULT_BLOCK_W = 128;
   localparam int DEFAULT_ADDR_W  = 6;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_XFER = 2'd1,
      D_XFER = 2'd2,
      DONE   = 2'd3
   } arb_state_t;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   // Maps a granted port onto the transfer state that serves it.
   function automatic arb_state_t xfer_state(input logic port);
      return (port == PORT_D) ? D_XFER : I_XFER;
   endfunction

endpackage

// File: rtl/arb_pick.sv
// Winner selection for the memory arbiter.
// Build option: ARB_ROUND_ROBIN_EN -- when defined, simultaneous requests go
// to the port that was not granted last; otherwise the data cache always wins.
module arb_pick
   import mem_arb_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic i_req,
   input  logic d_req,
   input  logic grant,
   output logic winner
);

`ifdef ARB_ROUND_ROBIN_EN
   logic last_grant;

   // Remember which port received the most recent grant so ties alternate.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last_grant <= PORT_I;
      end else if (grant) begin
         last_grant <= winner;
      end
   end

   // Tie goes to the port that did not win last time; a lone request wins outright.
   always_comb begin
      winner = PORT_I;
      if (i_req && d_req) begin
         winner = (last_grant == PORT_I) ? PORT_D : PORT_I;
      end else if (d_req) begin
         winner = PORT_D;
      end
   end
`else
   logic unused_fixed_priority;
   assign unused_fixed_priority = clock ^ reset ^ grant ^ i_req;

   // Fixed priority: the data cache wins whenever it is requesting.
   always_comb begin
      winner = PORT_I;
      if (d_req) begin
         winner = PORT_D;
      end
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction cache / data cache) arbiter in front of a single
// block-wide memory. One transfer at a time; memory-side outputs and the
// per-port readdata registers are all registered.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin tie breaking inside
// arb_pick; the default build uses data-cache priority.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int BLOCK_W = DEFAULT_BLOCK_W,
   parameter int ADDR_W  = DEFAULT_ADDR_W
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               i_read,
   input  logic [ADDR_W-1:0]  i_address,
   output logic [BLOCK_W-1:0] i_readdata,
   output logic               i_busywait,
   input  logic               d_read,
   input  logic               d_write,
   input  logic [ADDR_W-1:0]  d_address,
   input  logic [BLOCK_W-1:0] d_writedata,
   output logic [BLOCK_W-1:0] d_readdata,
   output logic               d_busywait,
   output logic               mem_read,
   output logic               mem_write,
   output logic [ADDR_W-1:0]  mem_address,
   output logic [BLOCK_W-1:0] mem_writedata,
   input  logic [BLOCK_W-1:0] mem_readdata,
   input  logic               mem_busywait
);

   arb_state_t         state, next_state;
   logic               owner, next_owner;
   logic               first_cycle, next_first_cycle;
   logic               next_mem_read, next_mem_write;
   logic [ADDR_W-1:0]  next_mem_address;
   logic [BLOCK_W-1:0] next_mem_writedata;
   logic [BLOCK_W-1:0] next_i_readdata, next_d_readdata;
   logic               d_req, req_any, grant, winner;

   assign d_req   = d_read | d_write;
   assign req_any = i_read | d_req;
   assign grant   = (state == IDLE) && req_any;

   arb_pick u_pick (
      .clock  (clock),
      .reset  (reset),
      .i_req  (i_read),
      .d_req  (d_req),
      .grant  (grant),
      .winner (winner)
   );

   // A port is released only during the DONE cycle of its own transfer;
   // the other port keeps stalling for as long as it is requesting.
   assign i_busywait = i_read & ~((state == DONE) && (owner == PORT_I));
   assign d_busywait = d_req  & ~((state == DONE) && (owner == PORT_D));

   // Next-state and next-register values: grant in IDLE, wait out memory in
   // XFER (ignoring busywait on the first cycle), then a single DONE cycle.
   always_comb begin
      next_state         = state;
      next_owner         = owner;
      next_first_cycle   = first_cycle;
      next_mem_read      = mem_read;
      next_mem_write     = mem_write;
      next_mem_address   = mem_address;
      next_mem_writedata = mem_writedata;
      next_i_readdata    = i_readdata;
      next_d_readdata    = d_readdata;

      case (state)
         IDLE: begin
            if (req_any) begin
               next_state       = xfer_state(winner);
               next_owner       = winner;
               next_first_cycle = 1'b1;
               if (winner == PORT_D) begin
                  next_mem_address   = d_address;
                  next_mem_writedata = d_writedata;
                  next_mem_write     = d_write;
                  next_mem_read      = ~d_write;
               end else begin
                  next_mem_address = i_address;
                  next_mem_read    = 1'b1;
                  next_mem_write   = 1'b0;
               end
            end
         end
         I_XFER, D_XFER: begin
            if (first_cycle) begin
               next_first_cycle = 1'b0;
            end else if (!mem_busywait) begin
               next_mem_read  = 1'b0;
               next_mem_write = 1'b0;
               next_state     = DONE;
               if (mem_read) begin
                  if (owner == PORT_I) begin
                     next_i_readdata = mem_readdata;
                  end else begin
                     next_d_readdata = mem_readdata;
                  end
               end
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any transfer in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         owner         <= PORT_I;
         first_cycle   <= 1'b0;
         mem_read      <= 1'b0;
         mem_write     <= 1'b0;
         mem_address   <= '0;
         mem_writedata <= '0;
         i_readdata    <= '0;
         d_readdata    <= '0;
      end else begin
         state         <= next_state;
         owner         <= next_owner;
         first_cycle   <= next_first_cycle;
         mem_read      <= next_mem_read;
         mem_write     <= next_mem_write;
         mem_address   <= next_mem_address;
         mem_writedata <= next_mem_writedata;
         i_readdata    <= next_i_readdata;
         d_readdata    <= next_d_readdata;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a behavioural memory with programmable busy time,
// two cache-like requesters, and a transaction-level reference model that
// predicts service order, latency, readdata and the memory operations seen.
// Define ARB_ROUND_ROBIN_EN for both DUT and bench to exercise round robin.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int BW = 128;
   localparam int AW = 6;

   logic          clock, reset;
   logic          i_read;
   logic [AW-1:0] i_address;
   logic [BW-1:0] i_readdata;
   logic          i_busywait;
   logic          d_read, d_write;
   logic [AW-1:0] d_address;
   logic [BW-1:0] d_writedata;
   logic [BW-1:0] d_readdata;
   logic          d_busywait;
   logic          mem_read, mem_write;
   logic [AW-1:0] mem_address;
   logic [BW-1:0] mem_writedata;
   logic [BW-1:0] mem_readdata;
   logic          mem_busywait;

   typedef struct {
      logic          rd;
      logic          wr;
      logic [AW-1:0] addr;
      logic [BW-1:0] wdata;
   } mem_op_t;

   int            vectors = 0;
   int            miscompares = 0;
   int            busy_cycles = 1;
   logic [BW-1:0] mem_array [64];
   logic [BW-1:0] ref_mem [64];
   logic [BW-1:0] exp_i_rd, exp_d_rd;
   logic          rr_last;
   mem_op_t       mem_log [$];
   mem_op_t       exp_log [$];

   mem_arbiter #(.BLOCK_W(BW), .ADDR_W(AW)) dut (
      .clock         (clock),
      .reset         (reset),
      .i_read        (i_read),
      .i_address     (i_address),
      .i_readdata    (i_readdata),
      .i_busywait    (i_busywait),
      .d_read        (d_read),
      .d_write       (d_write),
      .d_address     (d_address),
      .d_writedata   (d_writedata),
      .d_readdata    (d_readdata),
      .d_busywait    (d_busywait),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_address   (mem_address),
      .mem_writedata (mem_writedata),
      .mem_readdata  (mem_readdata),
      .mem_busywait  (mem_busywait)
   );

   // Free-running clock, 10 time units per cycle.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Hard stop in case something wedges.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [BW-1:0] rand_block();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic checkOutput(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Memory: raises busywait the negedge after a command appears, holds it for
   // busy_cycles further cycles, then drops it with the read data (or commits
   // the write) and logs the operation as seen at completion.
   initial begin
      int      mstate;
      int      cnt;
      mem_op_t op;
      mem_busywait = 1'b0;
      mem_readdata = '0;
      mstate = 0;
      cnt = 0;
      forever begin
         @(negedge clock);
         if (!(mem_read || mem_write)) begin
            mstate = 0;
            mem_busywait = 1'b0;
         end else if (mstate == 0) begin
            mstate = 1;
            cnt = busy_cycles;
            mem_busywait = 1'b1;
            mem_readdata = rand_block();
         end else if (mstate == 1) begin
            if (cnt == 0) begin
               op.rd = mem_read;
               op.wr = mem_write;
               op.addr = mem_address;
               op.wdata = mem_writedata;
               mem_log.push_back(op);
               if (mem_write) begin
                  mem_array[mem_address] = mem_writedata;
                  mem_readdata = rand_block();
               end else begin
                  mem_readdata = mem_array[mem_address];
               end
               mem_busywait = 1'b0;
               mstate = 2;
            end else begin
               cnt--;
               mem_readdata = rand_block();
            end
         end
      end
   end

   // Reference model: one instruction-cache block read.
   task automatic modelI(input logic [AW-1:0] a);
      mem_op_t e;
      e.rd = 1'b1;
      e.wr = 1'b0;
      e.addr = a;
      e.wdata = '0;
      exp_log.push_back(e);
      exp_i_rd = ref_mem[a];
      rr_last = PORT_I;
   endtask

   // Reference model: one data-cache read or write-back (write wins if both).
   task automatic modelD(input logic [AW-1:0] a, input bit wr, input logic [BW-1:0] wd);
      mem_op_t e;
      e.rd = !wr;
      e.wr = wr;
      e.addr = a;
      e.wdata = wd;
      exp_log.push_back(e);
      if (wr) ref_mem[a] = wd;
      else exp_d_rd = ref_mem[a];
      rr_last = PORT_D;
   endtask

   // Behaves like a stalled cache: waits for its busywait to drop, checks
   // latency and readdata, confirms the stall returns next cycle, then lets go.
   task automatic servePort(input bit is_d, input int exp_lat, input bit scramble);
      int    cyc;
      bit    seen;
      string nm;
      nm = is_d ? "d" : "i";
      cyc = 0;
      seen = 1'b0;
      while (!seen && cyc < 200) begin
         @(posedge clock);
         cyc++;
         if (cyc == 1 && scramble) begin
            #1;
            if (is_d) begin
               d_address = AW'($urandom);
               d_writedata = rand_block();
            end else begin
               i_address = AW'($urandom);
            end
         end
         @(negedge clock);
         if ((is_d ? d_busywait : i_busywait) == 1'b0) seen = 1'b1;
      end
      checkOutput({nm, "_release_seen"}, BW'(seen), BW'(1));
      checkOutput({nm, "_latency"}, BW'(cyc), BW'(exp_lat));
      checkOutput({nm, "_readdata"}, is_d ? d_readdata : i_readdata, is_d ? exp_d_rd : exp_i_rd);
      @(negedge clock);
      checkOutput({nm, "_busy_after_done"}, BW'(is_d ? d_busywait : i_busywait), BW'(1));
      if (is_d) begin
         d_read = 1'b0;
         d_write = 1'b0;
      end else begin
         i_read = 1'b0;
      end
   endtask

   // One arbitration round: predict order and results, raise the requests on
   // the same edge, serve both ports concurrently, then compare memory ops.
   task automatic applyStimulus(input bit use_i, input bit use_d, input bit d_rd, input bit d_wr,
                                input logic [AW-1:0] ia, input logic [AW-1:0] da,
                                input logic [BW-1:0] wd, input int n);
      bit      d_first;
      int      lat_first, lat_second;
      mem_op_t g, x;
      busy_cycles = n;
      exp_log.delete();
      mem_log.delete();
      if (use_i && use_d) begin
`ifdef ARB_ROUND_ROBIN_EN
         d_first = (rr_last == PORT_I);
`else
         d_first = 1'b1;
`endif
      end else begin
         d_first = use_d;
      end
      if (use_i && use_d) begin
         if (d_first) begin
            modelD(da, d_wr, wd);
            modelI(ia);
         end else begin
            modelI(ia);
            modelD(da, d_wr, wd);
         end
      end else if (use_d) begin
         modelD(da, d_wr, wd);
      end else begin
         modelI(ia);
      end
      lat_first = n + 3;
      lat_second = 2 * n + 7;
      @(negedge clock);
      i_read = use_i;
      i_address = ia;
      d_read = use_d & d_rd;
      d_write = use_d & d_wr;
      d_address = da;
      d_writedata = wd;
      fork
         if (use_i) servePort(1'b0, (use_d && d_first) ? lat_second : lat_first, !(use_d && d_first));
         if (use_d) servePort(1'b1, (use_i && !d_first) ? lat_second : lat_first, d_first);
      join
      repeat (n + 6) @(negedge clock);
      checkOutput("mem_op_count", BW'(mem_log.size()), BW'(exp_log.size()));
      for (int k = 0; k < mem_log.size() && k < exp_log.size(); k++) begin
         g = mem_log[k];
         x = exp_log[k];
         checkOutput("mem_op_read", BW'(g.rd), BW'(x.rd));
         checkOutput("mem_op_write", BW'(g.wr), BW'(x.wr));
         checkOutput("mem_op_addr", BW'(g.addr), BW'(x.addr));
         if (x.wr) checkOutput("mem_op_wdata", g.wdata, x.wdata);
      end
   endtask

   // Main sequence: reset values, directed cases, mid-transfer reset, random rounds.
   initial begin
      logic [BW-1:0] a5_block;
      logic [BW-1:0] pat_block;
      int            sel, dk;
      a5_block = {16{8'hA5}};
      pat_block = 128'h123456789ABCDEF0_0FEDCBA987654321;
      reset = 1'b1;
      i_read = 1'b0;
      i_address = '0;
      d_read = 1'b0;
      d_write = 1'b0;
      d_address = '0;
      d_writedata = '0;
      exp_i_rd = '0;
      exp_d_rd = '0;
      rr_last = PORT_I;
      for (int k = 0; k < 64; k++) begin
         mem_array[k] = rand_block();
         ref_mem[k] = mem_array[k];
      end
      mem_array[5] = a5_block;
      ref_mem[5] = a5_block;

      repeat (2) @(negedge clock);
      checkOutput("rst_mem_read", BW'(mem_read), BW'(0));
      checkOutput("rst_mem_write", BW'(mem_write), BW'(0));
      checkOutput("rst_mem_address", BW'(mem_address), BW'(0));
      checkOutput("rst_mem_writedata", mem_writedata, '0);
      checkOutput("rst_i_readdata", i_readdata, '0);
      checkOutput("rst_d_readdata", d_readdata, '0);
      checkOutput("rst_i_busywait", BW'(i_busywait), BW'(0));
      checkOutput("rst_d_busywait", BW'(d_busywait), BW'(0));
      reset = 1'b0;
      $display("[TB] reset released");

      // Lone instruction read of the A5 block, five busy cycles.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 6'h05, 6'h00, '0, 5);
      checkOutput("i_read_a5", i_readdata, a5_block);

      // Reset in the third busy cycle of an instruction read.
      busy_cycles = 5;
      mem_log.delete();
      @(negedge clock);
      i_read = 1'b1;
      i_address = 6'h05;
      repeat (4) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      #1;
      checkOutput("midrst_mem_read", BW'(mem_read), BW'(0));
      checkOutput("midrst_state", BW'(dut.state), BW'(IDLE));
      checkOutput("midrst_i_readdata", i_readdata, '0);
      checkOutput("midrst_i_busywait", BW'(i_busywait), BW'(1));
      @(negedge clock);
      reset = 1'b0;
      i_read = 1'b0;
      exp_i_rd = '0;
      exp_d_rd = '0;
      rr_last = PORT_I;
      repeat (8) @(negedge clock);
      checkOutput("midrst_no_mem_op", BW'(mem_log.size()), BW'(0));

      // Lone write-back to the top address.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 6'h00, 6'h3F, pat_block, 3);
      // Read and write together must be treated as a write.
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 6'h00, 6'h21, rand_block(), 2);
      // Data read first, then simultaneous instruction and data reads.
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 6'h00, 6'h3F, '0, 1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 6'h05, 6'h3F, '0, 2);

      $display("[TB] random rounds");
      for (int r = 0; r < 30; r++) begin
         sel = $urandom_range(0, 2);
         dk = $urandom_range(0, 2);
         applyStimulus(sel != 1, sel != 0, dk != 1, dk != 0,
                       AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
                       rand_block(), $urandom_range(1, 5));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
- REQ-001 The block SHALL have parameter BLOCK_W, default 128, meaning cache block width in bits.
- REQ-002 The block SHALL have parameter ADDR_W, default 6, meaning block address width.
- REQ-003 Port `clock`, input, 1: rising-edge clock.
- REQ-004 Port `reset`, input, 1: reset, asynchronous, active-high.
- REQ-005 Port `i_read`, input, 1: instruction-cache block read request.
- REQ-006 Port `i_address`, input, ADDR_W: instruction-cache block address.
- REQ-007 Port `i_readdata`, output, BLOCK_W: registered block returned to the instruction cache.
- REQ-008 Port `i_busywait`, output, 1: instruction-cache stall.
- REQ-009 Port `d_read` / `d_write`, input, 1 each: data-cache read and write-back requests.
- REQ-010 Port `d_address`, input, ADDR_W; port `d_writedata`, input, BLOCK_W: data-cache address and write-back block.
- REQ-011 Port `d_readdata`, output, BLOCK_W: registered block returned to the data cache.
- REQ-012 Port `d_busywait`, output, 1: data-cache stall.
- REQ-013 Memory-side ports: `mem_read` (output, 1), `mem_write` (output, 1), `mem_address` (output, ADDR_W), `mem_writedata` (output, BLOCK_W), `mem_readdata` (input, BLOCK_W), `mem_busywait` (input, 1).

Function
- REQ-014 The FSM SHALL have states IDLE, I_XFER, D_XFER and DONE; `mem_*` outputs are registered.
- REQ-015 Grants are issued in IDLE only:
  - a sampled request moves the FSM to I_XFER or D_XFER;
  - the owner is latched;
  - `mem_address` and `mem_writedata` are latched from the winner;
  - `mem_read` or `mem_write` is set.
- REQ-016 With `d_read` and `d_write` both high, the block SHALL treat the request as a write.
- REQ-017 The first cycle of an XFER state SHALL ignore `mem_busywait`, giving memory one cycle to raise it.
- REQ-018 In later XFER cycles, a posedge sampling `mem_busywait`=0 completes the transfer:
  - `mem_read` and `mem_write` clear;
  - for a read, `mem_readdata` is latched into the owner's readdata register;
  - the FSM moves to DONE.
- REQ-019 DONE SHALL last exactly one cycle and always return to IDLE without granting, so a request still high at the DONE-exit edge is not re-served.
- REQ-020 `i_busywait` = `i_read` AND NOT (state==DONE AND owner==I), combinational; `d_busywait` is the same using (`d_read` OR `d_write`) and owner==D.
- REQ-021 The non-owning requester SHALL see busywait high throughout another port's transfer.
- REQ-022 Readdata registers SHALL hold their value except at completion of a read by their own port; `d_readdata` is unchanged on writes.
- REQ-023 Request changes during XFER SHALL NOT affect the latched address, data or command.
- REQ-024 Minimum latency is 1 grant cycle + N memory-busy cycles + 1 DONE cycle.

Reset
- REQ-025 Reset SHALL asynchronously force:
  - state IDLE;
  - `mem_read`=0, `mem_write`=0;
  - `mem_address`=0, `mem_writedata`=0;
  - `i_readdata`=0, `d_readdata`=0;
  - owner=I, last_grant=I.
- REQ-026 Reset asserted mid-transfer SHALL abandon the transfer with no readdata update; the busywait outputs continue to follow REQ-020 during reset.

Configuration
- REQ-027 With macro ARB_ROUND_ROBIN_EN defined, simultaneous requests in IDLE SHALL be granted to the port not equal to last_grant; last_grant updates on every grant.
- REQ-028 Without ARB_ROUND_ROBIN_EN, the data cache SHALL always win simultaneous requests, and last_grant SHALL be absent.

Structure
- REQ-029 Package mem_arb_pkg SHALL hold the state encoding, the port-ID constants (PORT_I, PORT_D) and the default widths.
- REQ-030 A sub-module arb_pick SHALL compute the winner combinationally from the requests and last_grant; the macro is applied only inside it.

Verification
- REQ-031 Lone `i_read`, address 6'h05, memory busy 5 cycles returning 128'hA5..A5:
  - `i_readdata`=128'hA5..A5 in DONE;
  - `i_busywait` falls for exactly that cycle;
  - no second `mem_read`.
- REQ-032 Lone `d_write`, address 6'h3F, data 128'h1234..: `mem_write`=1, `mem_address`=6'h3F, `mem_writedata` matches, and `d_readdata` is unchanged.
- REQ-033 `i_read` and `d_read` rise on the same edge:
  - without the macro, D is served first, then I;
  - with the macro after a prior D grant, I is served first;
  - the stalled port's busywait stays 1.
- REQ-034 Reset pulsed in the 3rd busy cycle of an I read: `mem_read`=0 immediately, state IDLE, and `i_readdata`=0.
- REQ-035 `d_read` and `d_write` both high: only `mem_write`=1 is driven.
